// File: rtl/bram_block_pkg.sv
// bram_block_pkg: shared constants, FSM states and helpers for the dual-port BRAM engine.
package bram_block_pkg;
  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;
  typedef enum logic {CLEAR, RUN} state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Lane k of wen selects byte k (numeric order) of the new word.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_w, input logic [63:0] new_w, input logic [7:0] wen);
    logic [63:0] r = old_w;
    for (int i = 0; i < 8; i++) if (wen[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/bram_block_dp_engine_if.sv
// bram_block_dp_engine_if: both LMB-side BRAM ports plus engine status.
interface bram_block_dp_engine_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NW = DW / 8
);
  logic          BRAM_EN_A, BRAM_EN_B;
  logic [0:NW-1] BRAM_WEN_A, BRAM_WEN_B;
  logic [0:AW-1] BRAM_Addr_A, BRAM_Addr_B;
  logic [0:DW-1] BRAM_Din_A, BRAM_Din_B;
  logic [0:DW-1] BRAM_Dout_A, BRAM_Dout_B;
  logic          Init_Busy, Collision;
  modport master (
    output BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
    output BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
    input  BRAM_Din_A, BRAM_Din_B, Init_Busy, Collision
  );
  modport slave (
    input  BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
    input  BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
    output BRAM_Din_A, BRAM_Din_B, Init_Busy, Collision
  );
endinterface

// File: rtl/bram_block_port_pipe.sv
// bram_block_port_pipe: per-port read data path (write-mode mux, optional second register, hold on idle).
module bram_block_port_pipe
  import bram_block_pkg::*;
#(
  parameter int DW           = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = WM_READ_FIRST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [DW-1:0] old_w,
  input  logic [DW-1:0] new_w,
  output logic [DW-1:0] din
);
  logic [DW-1:0] d1, d2, nxt;
  always_comb nxt = !we ? old_w : WRITE_MODE == WM_WRITE_FIRST ? new_w : WRITE_MODE == WM_NO_CHANGE ? d1 : old_w;
  // d1 only moves on an access, so d2 tracking it unconditionally also holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      if (en) d1 <= nxt;
      d2 <= d1;
    end
  end
  assign din = READ_LATENCY == 2 ? d2 : d1;
endmodule

// File: rtl/bram_block_dp_engine.sv
// bram_block_dp_engine: true dual-port BRAM with collision resolution and post-reset clear sweep.
module bram_block_dp_engine
  import bram_block_pkg::*;
#(
  parameter int    C_MEMSIZE      = 'h8000,
  parameter int    C_PORT_DWIDTH  = 32,
  parameter int    C_PORT_AWIDTH  = 32,
  parameter int    C_NUM_WE       = C_PORT_DWIDTH / 8,
  parameter int    C_READ_LATENCY = 1,
  parameter int    C_WRITE_MODE   = 0,
  parameter int    C_INIT_CLEAR   = 1,
  parameter string C_FAMILY       = "spartan6"
) (
  input logic BRAM_Clk,
  input logic BRAM_Rst,
  bram_block_dp_engine_if.slave bus
);
  localparam int DW    = C_PORT_DWIDTH;
  localparam int AW    = C_PORT_AWIDTH;
  localparam int BOFS  = clog2(C_NUM_WE);
  localparam int DEPTH = C_MEMSIZE / C_NUM_WE;
  localparam int AB    = clog2(DEPTH);
  state_e state, state_nxt;
  logic [AB-1:0] clr_cnt, idx_a, idx_b;
  logic run, en_a, en_b, we_a, we_b, same, col, unused_ok;
  logic [7:0] wen_a, wen_b;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] old_a, old_b, new_a, new_b, new_ab;
  // The family string is informational; no family-specific logic exists.
  if (C_FAMILY == "") begin : g_no_family
  end
  assign run = state == RUN && !BRAM_Rst;
  assign en_a = run && bus.BRAM_EN_A;
  assign en_b = run && bus.BRAM_EN_B;
  assign wen_a = 8'(bus.BRAM_WEN_A);
  assign wen_b = 8'(bus.BRAM_WEN_B);
  assign we_a = en_a && |wen_a;
  assign we_b = en_b && |wen_b;
  assign idx_a = bus.BRAM_Addr_A[AW-BOFS-AB : AW-BOFS-1];
  assign idx_b = bus.BRAM_Addr_B[AW-BOFS-AB : AW-BOFS-1];
  assign unused_ok = ^{bus.BRAM_Addr_A, bus.BRAM_Addr_B};
  assign same = idx_a == idx_b;
  assign old_a = mem[idx_a];
  assign old_b = mem[idx_b];
  assign new_a = DW'(byte_merge(64'(old_a), 64'(bus.BRAM_Dout_A), wen_a));
  assign new_b = DW'(byte_merge(64'(old_b), 64'(bus.BRAM_Dout_B), wen_b));
  // Dual write to one word: layer A's lanes over B's merge so A wins per lane.
  assign new_ab = DW'(byte_merge(64'(new_b), 64'(bus.BRAM_Dout_A), wen_a));
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state <= C_INIT_CLEAR != 0 ? CLEAR : RUN;
      clr_cnt <= '0;
      col <= 1'b0;
    end else begin
      state <= state_nxt;
      clr_cnt <= state == CLEAR ? clr_cnt + AB'(1) : clr_cnt;
      col <= en_a && en_b && same && (we_a || we_b);
    end
  end
  always_comb begin
    state_nxt = state == CLEAR && clr_cnt == AB'(DEPTH - 1) ? RUN : state;
    bus.Init_Busy = state == CLEAR;
  end
  always_ff @(posedge BRAM_Clk) begin
    if (!BRAM_Rst && state == CLEAR) mem[clr_cnt] <= '0;
    else begin
      if (we_b && !(same && we_a)) mem[idx_b] <= new_b;
      if (we_a) mem[idx_a] <= same && we_b ? new_ab : new_a;
    end
  end
  assign bus.Collision = col;
  bram_block_port_pipe #(.DW(DW), .READ_LATENCY(C_READ_LATENCY), .WRITE_MODE(C_WRITE_MODE)) u_pipe_a (
    .clk(BRAM_Clk), .rst(BRAM_Rst), .en(en_a), .we(we_a), .old_w(old_a), .new_w(new_a), .din(bus.BRAM_Din_A)
  );
  bram_block_port_pipe #(.DW(DW), .READ_LATENCY(C_READ_LATENCY), .WRITE_MODE(C_WRITE_MODE)) u_pipe_b (
    .clk(BRAM_Clk), .rst(BRAM_Rst), .en(en_b), .we(we_b), .old_w(old_b), .new_w(new_b), .din(bus.BRAM_Din_B)
  );
endmodule

// File: tb/tb_bram_block_dp_engine.sv
// tb_bram_block_dp_engine: two engines (latency1/read-first, latency2/write-first) on shared stimulus.
module tb_bram_block_dp_engine;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bram_block_dp_engine_if i0 (), i1 ();
  assign i1.BRAM_EN_A = i0.BRAM_EN_A;
  assign i1.BRAM_WEN_A = i0.BRAM_WEN_A;
  assign i1.BRAM_Addr_A = i0.BRAM_Addr_A;
  assign i1.BRAM_Dout_A = i0.BRAM_Dout_A;
  assign i1.BRAM_EN_B = i0.BRAM_EN_B;
  assign i1.BRAM_WEN_B = i0.BRAM_WEN_B;
  assign i1.BRAM_Addr_B = i0.BRAM_Addr_B;
  assign i1.BRAM_Dout_B = i0.BRAM_Dout_B;
  bram_block_dp_engine #(.C_READ_LATENCY(1), .C_WRITE_MODE(0)) u_rf1 (.BRAM_Clk(clk), .BRAM_Rst(rst), .bus(i0));
  bram_block_dp_engine #(.C_READ_LATENCY(2), .C_WRITE_MODE(1)) u_wf2 (.BRAM_Clk(clk), .BRAM_Rst(rst), .bus(i1));
  typedef struct {
    int          due;
    int          dut;
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;
  exp_t sb[$];
  logic [31:0] model [8192];
  logic [31:0] last [2][2];
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] obs(input int d, input int p);
    if (d == 0) return p == 0 ? i0.BRAM_Din_A : p == 1 ? i0.BRAM_Din_B : {31'b0, i0.Collision};
    return p == 0 ? i1.BRAM_Din_A : p == 1 ? i1.BRAM_Din_B : {31'b0, i1.Collision};
  endfunction
  // Lane i of the enable covers data bits [8i:8i+7] of the big-endian word.
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [0:3] w);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[31-8*i -: 8] = n[31-8*i -: 8];
    return r;
  endfunction
  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs(sb[i].dut, sb[i].port), sb[i].exp);
        sb.delete(i);
      end
  task automatic drive(input logic ea, input logic [0:3] wa, input logic [31:0] aa, input logic [31:0] da,
                       input logic eb, input logic [0:3] wb, input logic [31:0] ab, input logic [31:0] db);
    i0.BRAM_EN_A = ea; i0.BRAM_WEN_A = wa; i0.BRAM_Addr_A = aa; i0.BRAM_Dout_A = da;
    i0.BRAM_EN_B = eb; i0.BRAM_WEN_B = wb; i0.BRAM_Addr_B = ab; i0.BRAM_Dout_B = db;
  endtask
  task automatic acc(input logic ea, input logic [0:3] wa, input logic [31:0] aa, input logic [31:0] da,
                     input logic eb, input logic [0:3] wb, input logic [31:0] ab, input logic [31:0] db,
                     input string tag);
    int ia, ib;
    logic [31:0] oa, ob;
    logic wra, wrb, coll;
    @(negedge clk);
    drive(ea, wa, aa, da, eb, wb, ab, db);
    ia = int'((aa >> 2) & 32'h1fff);
    ib = int'((ab >> 2) & 32'h1fff);
    oa = model[ia];
    ob = model[ib];
    wra = ea && wa != 0;
    wrb = eb && wb != 0;
    coll = ea && eb && ia == ib && (wra || wrb);
    if (wrb) model[ib] = mrg(model[ib], db, wb);
    if (wra) model[ia] = mrg(model[ia], da, wa);
    if (ea) begin
      last[0][0] = oa;
      last[1][0] = wra ? mrg(oa, da, wa) : oa;
    end
    if (eb) begin
      last[0][1] = ob;
      last[1][1] = wrb ? mrg(ob, db, wb) : ob;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) sb.push_back('{cyc + 1 + d, d, p, last[d][p], $sformatf("%s dut%0d din_%s", tag, d, p == 0 ? "a" : "b")});
      sb.push_back('{cyc + 1, d, 2, {31'b0, coll}, $sformatf("%s dut%0d collision", tag, d)});
    end
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) acc(0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 8192; w++) model[w] = '0;
    last = '{default: '0};
  endtask
  task automatic wait_clear(output int n);
    n = 0;
    while (i0.Init_Busy && n < 9000) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++) chk($sformatf("reset dut%0d port%0d", d, p), obs(d, p), 32'h0);
    chk("reset busy0", {31'b0, i0.Init_Busy}, 32'h1);
    chk("reset busy1", {31'b0, i1.Init_Busy}, 32'h1);
    rst = 1'b0;
    for (int w = 0; w < 8192; w++) model[w] = '0;
    last = '{default: '0};
    wait_clear(n);
    chk("init sweep cycles", 32'(n), 32'd8192);
    chk("busy1 after sweep", {31'b0, i1.Init_Busy}, 32'h0);
    acc(1, 4'b1111, 32'h10, 32'h12345678, 0, 0, 0, 0, "t2 write");
    acc(0, 0, 0, 0, 1, 0, 32'h10, 0, "t2 read");
    idle(2);
    acc(1, 4'b1111, 32'h10, 32'hAABBCCDD, 0, 0, 0, 0, "t3 full");
    acc(1, 4'b0101, 32'h10, 32'h11223344, 0, 0, 0, 0, "t3 lanes");
    acc(0, 0, 0, 0, 1, 0, 32'h10, 0, "t3 read");
    idle(1);
    acc(1, 4'b1100, 32'h0C, 32'h11112222, 1, 4'b0110, 32'h0C, 32'h33334444, "t4 ww");
    acc(1, 0, 32'h0C, 0, 0, 0, 0, 0, "t4 read");
    idle(1);
    acc(1, 4'b1111, 32'h18, 32'hCAFEF00D, 1, 0, 32'h18, 0, "t5 wr");
    idle(2);
    acc(1, 0, 32'h18, 0, 1, 0, 32'h18, 0, "both read");
    acc(1, 0, 32'h8010, 0, 1, 0, 32'h13, 0, "alias");
    idle(2);
    for (int k = 0; k < 40; k++)
      acc(1'($urandom_range(0, 1)), 4'($urandom), 32'(($urandom_range(0, 3) << 15) | ($urandom_range(8, 11) << 2) | $urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 1)), 4'($urandom), 32'(($urandom_range(0, 3) << 15) | ($urandom_range(8, 11) << 2) | $urandom_range(0, 3)), $urandom, "random");
    idle(1);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    acc(1, 4'b1111, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0, "t1 preload");
    acc(1, 0, 32'h14, 0, 0, 0, 0, 0, "t1 preread");
    idle(1);
    repeat (3) @(negedge clk);
    pulse_reset();
    wait_clear(n);
    chk("t1 sweep cycles", 32'(n), 32'd8192);
    acc(1, 0, 32'h14, 0, 1, 0, 32'h14, 0, "t1 cleared");
    idle(1);
    repeat (3) @(negedge clk);
    pulse_reset();
    n = 0;
    while (i0.Init_Busy && n < 9000) begin
      if (n >= 50 && n < 55) drive(1, 4'b1111, 32'h8, 32'h55AA55AA, 1, 0, 32'h8, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n++;
      if (n >= 51 && n <= 58)
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < 3; p++) chk($sformatf("sweep ignore n%0d dut%0d port%0d", n, d, p), obs(d, p), 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6 sweep cycles", 32'(n), 32'd8192);
    acc(1, 0, 32'h8, 0, 0, 0, 0, 0, "t6 ignored write");
    idle(1);
    repeat (3) @(negedge clk);
    pulse_reset();
    repeat (100) @(negedge clk);
    chk("busy at sweep 100", {31'b0, i0.Init_Busy}, 32'h1);
    pulse_reset();
    wait_clear(n);
    chk("restart sweep cycles", 32'(n), 32'd8192);
    acc(0, 0, 0, 0, 1, 4'b1111, 32'h20, 32'h0BADF00D, "post write");
    acc(1, 0, 32'h20, 0, 0, 0, 0, 0, "post read");
    idle(1);
    repeat (3) @(negedge clk);
    chk("final drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule
